// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous RAM between the fetch bus and the load/store bus.
// One access per cycle; read responses are routed back through a MEM_LAT-deep owner tag pipeline.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0]         streak_q, streak_d;
    logic [MEM_LAT-1:0] tag_vld_q;
    logic [MEM_LAT-1:0] tag_own_q;   // 1 = data bus owns the response
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      wdata_q;
    logic               d_win;

    always_comb begin
        d_win     = d_req & (~i_req | (streak_q < STREAK_MAX));
        d_gnt     = rst_n & d_win;
        i_gnt     = rst_n & i_req & ~d_win;
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
            mem_wdata = '0;
        end

        // Counts data wins while fetch is waiting; any fetch grant or idle fetch resets it.
        streak_d = streak_q;
        if (!i_req || i_gnt) begin
            streak_d = 4'd0;
        end else if (d_gnt && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q  <= 4'd0;
            tag_vld_q <= '0;
            tag_own_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            streak_q <= streak_d;
            if (mem_en) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            for (int k = MEM_LAT - 1; k > 0; k--) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_own_q[k] <= tag_own_q[k-1];
            end
            tag_vld_q[0] <= mem_en & ~mem_we;
            tag_own_q[0] <= d_gnt;
        end
    end

    assign i_rvalid = rst_n & tag_vld_q[MEM_LAT-1] & ~tag_own_q[MEM_LAT-1];
    assign d_rvalid = rst_n & tag_vld_q[MEM_LAT-1] &  tag_own_q[MEM_LAT-1];
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule
